// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// - ALU_OP_*  : 4-bit op-select encoding understood by the external alu.
// - state_t   : arbiter FSM state encoding.
// - is_divmod : true for the ops whose divisor must be non-zero.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD    = 4'd0;
    localparam logic [3:0] ALU_OP_SUB    = 4'd1;
    localparam logic [3:0] ALU_OP_MUL    = 4'd2;
    localparam logic [3:0] ALU_OP_DIV    = 4'd3;
    localparam logic [3:0] ALU_OP_MOD    = 4'd4;
    localparam logic [3:0] ALU_OP_AND    = 4'd5;
    localparam logic [3:0] ALU_OP_OR     = 4'd6;
    localparam logic [3:0] ALU_OP_XOR    = 4'd7;
    localparam logic [3:0] ALU_OP_SHL    = 4'd8;
    localparam logic [3:0] ALU_OP_SHR    = 4'd9;
    localparam logic [3:0] ALU_OP_SRA    = 4'd10;
    localparam logic [3:0] ALU_OP_SLT    = 4'd11;
    localparam logic [3:0] ALU_OP_SLTU   = 4'd12;
    localparam logic [3:0] ALU_OP_NAND   = 4'd13;
    localparam logic [3:0] ALU_OP_NOR    = 4'd14;
    localparam logic [3:0] ALU_OP_PASS_A = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_divmod(input logic [3:0] op);
        return (op == ALU_OP_DIV) || (op == ALU_OP_MOD);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
// Ports:
//   valid0, valid1 : requests
//   last_served    : id of the requester granted most recently
//   grant0, grant1 : one-hot (or zero) grant
// A lone request always wins; on a tie the requester that was not served
// last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_served,
    output logic grant0,
    output logic grant1
);

    assign grant0 = valid0 & (~valid1 | last_served);
    assign grant1 = valid1 & (~valid0 | ~last_served);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational alu between two requesters.
// An accepted op is held on the alu inputs for ALU_LATENCY cycles, then the
// alu result is sampled and offered as a response tagged with the requester id.
// Ports:
//   signal_clk, signal_rst        : clock, asynchronous active-high reset
//   signal_reqN_valid/ready       : request handshake for requester N (0/1)
//   signal_reqN_A/B/op            : operands and op select for requester N
//   signal_alu_A/B/S              : drive the alu inputs
//   signal_alu_Y                  : alu result
//   signal_resp_valid/ready       : response handshake
//   signal_resp_Y/id/err          : result, issuing requester, div/mod-by-zero flag
//   signal_busy                   : high whenever the FSM is not IDLE
//
// Handshake semantics (both request ports and the response port): a transfer
// happens on a rising clock edge where valid and ready are both high. The
// source holds its payload stable while valid is high and ready is low; the
// sink's ready may depend combinationally on valid. Request ready is only ever
// high in IDLE and never for both requesters in the same cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 2
) (
    input  logic             signal_clk,
    input  logic             signal_rst,
    input  logic             signal_req0_valid,
    output logic             signal_req0_ready,
    input  logic [WIDTH-1:0] signal_req0_A,
    input  logic [WIDTH-1:0] signal_req0_B,
    input  logic [3:0]       signal_req0_op,
    input  logic             signal_req1_valid,
    output logic             signal_req1_ready,
    input  logic [WIDTH-1:0] signal_req1_A,
    input  logic [WIDTH-1:0] signal_req1_B,
    input  logic [3:0]       signal_req1_op,
    output logic [WIDTH-1:0] signal_alu_A,
    output logic [WIDTH-1:0] signal_alu_B,
    output logic [3:0]       signal_alu_S,
    input  logic [WIDTH-1:0] signal_alu_Y,
    output logic             signal_resp_valid,
    input  logic             signal_resp_ready,
    output logic [WIDTH-1:0] signal_resp_Y,
    output logic             signal_resp_id,
    output logic             signal_resp_err,
    output logic             signal_busy
);

    localparam int               CNT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    state_t             state_n;
    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               exec_done;
    logic               last_served;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    logic [3:0]         cap_op;
    logic               cap_id;
    logic [WIDTH-1:0]   resp_y;
    logic               resp_err;
    logic               div_by_zero;

    rr_arb2 u_rr_arb2 (
        .valid0      (signal_req0_valid),
        .valid1      (signal_req1_valid),
        .last_served (last_served),
        .grant0      (grant0),
        .grant1      (grant1)
    );

    // Reset gates ready directly: state already reads IDLE while reset is
    // asserted, and no requester may see a ready during reset.
    assign signal_req0_ready = ~signal_rst & (state == ST_IDLE) & grant0;
    assign signal_req1_ready = ~signal_rst & (state == ST_IDLE) & grant1;

    assign div_by_zero = is_divmod(cap_op) && (cap_b == '0);

    // FSM state register
    always_ff @(posedge signal_clk or posedge signal_rst) begin
        if (signal_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        exec_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    accept  = 1'b1;
                    state_n = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    exec_done = 1'b1;
                    state_n   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (signal_resp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Capture registers, latency counter and response registers
    always_ff @(posedge signal_clk or posedge signal_rst) begin
        if (signal_rst) begin
            cap_a       <= '0;
            cap_b       <= '0;
            cap_op      <= '0;
            cap_id      <= 1'b0;
            last_served <= 1'b1;   // req0 wins the first tie after reset
            cnt         <= '0;
            resp_y      <= '0;
            resp_err    <= 1'b0;
        end else if (accept) begin
            cap_a       <= grant1 ? signal_req1_A  : signal_req0_A;
            cap_b       <= grant1 ? signal_req1_B  : signal_req0_B;
            cap_op      <= grant1 ? signal_req1_op : signal_req0_op;
            cap_id      <= grant1;
            last_served <= grant1;
            cnt         <= CNT_LOAD;
        end else if (state == ST_EXEC) begin
            if (exec_done) begin
                // The alu output is meaningless for a zero divisor; report 0.
                resp_y   <= div_by_zero ? '0 : signal_alu_Y;
                resp_err <= div_by_zero;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // The alu always sees the capture registers, so its inputs cannot move
    // while an op is in flight regardless of what the requesters do.
    assign signal_alu_A      = cap_a;
    assign signal_alu_B      = cap_b;
    assign signal_alu_S      = cap_op;
    assign signal_resp_valid = (state == ST_RESP);
    assign signal_resp_Y     = resp_y;
    assign signal_resp_id    = cap_id;
    assign signal_resp_err   = resp_err;
    assign signal_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: an external alu stand-in, a request model that
// predicts grants and pushes expected responses, and a response monitor.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT ----------------
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic [3:0]   alu_s;
    logic         resp_valid, resp_id, resp_err, busy;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_y;

    alu_arbiter #(.WIDTH(W), .ALU_LATENCY(LAT)) dut (
        .signal_clk        (clk),
        .signal_rst        (rst),
        .signal_req0_valid (req0_valid),
        .signal_req0_ready (req0_ready),
        .signal_req0_A     (req0_a),
        .signal_req0_B     (req0_b),
        .signal_req0_op    (req0_op),
        .signal_req1_valid (req1_valid),
        .signal_req1_ready (req1_ready),
        .signal_req1_A     (req1_a),
        .signal_req1_B     (req1_b),
        .signal_req1_op    (req1_op),
        .signal_alu_A      (alu_a),
        .signal_alu_B      (alu_b),
        .signal_alu_S      (alu_s),
        .signal_alu_Y      (alu_y),
        .signal_resp_valid (resp_valid),
        .signal_resp_ready (resp_ready),
        .signal_resp_Y     (resp_y),
        .signal_resp_id    (resp_id),
        .signal_resp_err   (resp_err),
        .signal_busy       (busy)
    );

    // ---------------- reference arithmetic ----------------
    // Returns {err, y}: what the arbiter should report for one op.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
        logic [W-1:0] y;
        logic         err;
        y   = '0;
        err = 1'b0;
        case (op)
            ALU_OP_ADD:  y = a + b;
            ALU_OP_SUB:  y = a - b;
            ALU_OP_MUL:  y = a * b;
            ALU_OP_DIV:  if (b == '0) err = 1'b1; else y = $signed(a) / $signed(b);
            ALU_OP_MOD:  if (b == '0) err = 1'b1; else y = $signed(a) % $signed(b);
            ALU_OP_AND:  y = a & b;
            ALU_OP_OR:   y = a | b;
            ALU_OP_XOR:  y = a ^ b;
            ALU_OP_SHL:  y = a << b[4:0];
            ALU_OP_SHR:  y = a >> b[4:0];
            ALU_OP_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OP_SLT:  y = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            ALU_OP_SLTU: y = (a < b) ? W'(1) : W'(0);
            ALU_OP_NAND: y = ~(a & b);
            ALU_OP_NOR:  y = ~(a | b);
            default:     y = a;
        endcase
        return {err, y};
    endfunction

    // External alu stand-in: produces junk on a zero divisor, which the
    // arbiter must replace with 0.
    function automatic logic [W-1:0] alu_stub(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] op);
        logic [W:0] r;
        r = ref_op(a, b, op);
        return r[W] ? 32'hDEAD_BEEF : r[W-1:0];
    endfunction

    assign alu_y = alu_stub(alu_a, alu_b, alu_s);

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];   // {id, err, y}
    int n_vec = 0;
    int n_err = 0;
    int timeouts = 0;
    int timeouts_seen = 0;
    int accept_cyc = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Request-side model: who should be granted, what the alu should see,
    // and what response each accepted op must produce.
    logic         m_out  = 1'b0;   // an op is in flight (accepted, response not yet taken)
    logic         m_last = 1'b1;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [3:0]   m_op = '0;

    always @(negedge clk) begin
        logic e0, e1, id;
        if (rst) begin
            check("reset_outputs",
                  {req0_ready, req1_ready, resp_valid, busy, alu_a, alu_b, alu_s, resp_y, resp_id, resp_err},
                  '0);
            m_out  = 1'b0;
            m_last = 1'b1;
            exp_q.delete();
        end else begin
            e0 = !m_out && req0_valid && (!req1_valid || m_last);
            e1 = !m_out && req1_valid && (!req0_valid || !m_last);
            check("ready", {req0_ready, req1_ready}, {e0, e1});
            check("busy", busy, m_out);
            if (m_out) check("alu_inputs", {alu_a, alu_b, alu_s}, {m_a, m_b, m_op});
            if (m_out && resp_valid && resp_ready) begin
                m_out = 1'b0;
            end else if (e0 || e1) begin
                id   = e1;
                m_a  = id ? req1_a  : req0_a;
                m_b  = id ? req1_b  : req0_b;
                m_op = id ? req1_op : req0_op;
                exp_q.push_back({id, ref_op(m_a, m_b, m_op)});
                m_out      = 1'b1;
                m_last     = id;
                accept_cyc = cyc;
            end
        end
        if (timeouts != timeouts_seen) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_bound: %0d bounded waits expired, required 0", timeouts);
            timeouts_seen = timeouts;
        end
    end

    // Response monitor
    logic         prev_valid = 1'b0, prev_ready = 1'b0;
    logic [W+1:0] held = '0;

    always @(negedge clk) begin
        logic [W+1:0] exp;
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready)
                check("resp_hold", {resp_valid, resp_id, resp_err, resp_y}, {1'b1, held});
            if (resp_valid && !prev_valid)
                check("resp_latency", cyc - accept_cyc, LAT + 1);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected: got id=%0d y=%0h, required no response", resp_id, resp_y);
                end else begin
                    exp = exp_q.pop_front();
                    check("resp_data", {resp_id, resp_err, resp_y}, exp);
                end
            end
            held       = {resp_id, resp_err, resp_y};
            prev_valid = resp_valid;
            prev_ready = resp_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [3:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic rand_op(output logic [W-1:0] a, output logic [W-1:0] b, output logic [3:0] op);
        op = 4'($urandom_range(0, 15));
        a  = $urandom;
        b  = $urandom;
        case ($urandom_range(0, 3))
            0: b = '0;
            1: b = W'($urandom_range(1, 8));
            default: ;
        endcase
    endtask

    // One op from one requester, optionally holding resp_ready low for bp cycles.
    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input int bp);
        int guard;
        set_req(id, 1'b1, a, b, op);
        guard = 0;
        do begin @(negedge clk); guard++; end
        while (!(id ? req1_ready : req0_ready) && guard < 50);
        if (guard >= 50) timeouts++;
        @(posedge clk); #1;
        // Scramble the request lines while the op executes.
        set_req(id, 1'b0, $urandom, $urandom, 4'($urandom));
        if (bp > 0) resp_ready = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!resp_valid && guard < 50);
        if (guard >= 50) timeouts++;
        if (bp > 0) begin
            repeat (bp) @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        guard = 0;
        do begin @(negedge clk); guard++; end while (busy && guard < 50);
        if (guard >= 50) timeouts++;
        @(posedge clk); #1;
    endtask

    // n0/n1 random ops from each requester, valid held high until all sent.
    task automatic run_stream(input int n0, input int n1, input bit bp);
        int rem0, rem1, guard;
        logic acc0, acc1;
        logic [W-1:0] a, b;
        logic [3:0] op;
        rem0 = n0;
        rem1 = n1;
        rand_op(a, b, op); set_req(1'b0, rem0 > 0, a, b, op);
        rand_op(a, b, op); set_req(1'b1, rem1 > 0, a, b, op);
        resp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        guard = 0;
        while ((rem0 > 0 || rem1 > 0 || busy) && guard < 4000) begin
            @(negedge clk);
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            guard++;
            @(posedge clk); #1;
            if (acc0) begin rem0--; rand_op(a, b, op); set_req(1'b0, rem0 > 0, a, b, op); end
            if (acc1) begin rem1--; rand_op(a, b, op); set_req(1'b1, rem1 > 0, a, b, op); end
            resp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (guard >= 4000) timeouts++;
        resp_ready = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] a, b;
        logic [3:0] op;
        int guard;

        // Reset with both requesters valid: ready must stay low.
        rand_op(a, b, op); set_req(1'b0, 1'b1, a, b, op);
        rand_op(a, b, op); set_req(1'b1, 1'b1, a, b, op);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Tie at reset release: req0 then req1.
        run_stream(1, 1, 1'b0);

        // Single op: 7 + 5.
        send(1'b0, W'(7), W'(5), ALU_OP_ADD, 0);

        // Continuous contention: grants alternate.
        run_stream(6, 6, 1'b0);

        // Divide by zero, then a signed divide.
        send(1'b1, W'(9), W'(0), ALU_OP_DIV, 0);
        send(1'b1, -W'(9), W'(2), ALU_OP_DIV, 0);
        send(1'b0, W'(17), W'(0), ALU_OP_MOD, 0);

        // Backpressure on the response for 5 cycles.
        send(1'b0, $urandom, $urandom, ALU_OP_MUL, 5);

        // Reset during the second EXEC cycle of a req0 op.
        set_req(1'b0, 1'b1, W'(100), W'(23), ALU_OP_SUB);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!req0_ready && guard < 50);
        if (guard >= 50) timeouts++;
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
        @(posedge clk); #1;
        rand_op(a, b, op); set_req(1'b0, 1'b1, a, b, op);
        rand_op(a, b, op); set_req(1'b1, 1'b1, a, b, op);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_stream(1, 1, 1'b0);

        // Random traffic with random response backpressure.
        run_stream(20, 20, 1'b1);
        run_stream(15, 0, 1'b1);
        run_stream(0, 15, 1'b1);
        run_stream(10, 10, 1'b0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
